// File: rtl/mag_comp_serial_if.sv
// Slice stream into the serial magnitude comparator and the published result coming back.
// The bench drives through master; the comparator sits on slave.
interface mag_comp_serial_if;
    logic       in_valid;
    logic       start;
    logic       last;
    logic [1:0] a;
    logic [1:0] b;
    logic       busy;
    logic       out_valid;
    logic       gt;
    logic       lt;
    logic       eq;
    logic [3:0] cnt;
    logic       ovf;

    modport master (
        output in_valid, start, last, a, b,
        input  busy, out_valid, gt, lt, eq, cnt, ovf
    );

    modport slave (
        input  in_valid, start, last, a, b,
        output busy, out_valid, gt, lt, eq, cnt, ovf
    );
endinterface

// File: rtl/mag_comp_serial.sv
// Serial MSB-first magnitude comparator over 2-bit slices; result registered one cycle after the last slice.
// No back-pressure: one slice per cycle is always accepted.
module mag_comp_serial #(
    parameter int MAXSL = 8
) (
    input  logic             clk,
    input  logic             rst,
    mag_comp_serial_if.slave s
);
    typedef enum logic [1:0] {IDLE, RUN, DECIDED} state_t;

    state_t     state, state_n;
    logic       run_gt, run_lt, run_gt_n, run_lt_n;
    logic [3:0] cnt_q, cnt_n;
    logic       ovf_q, ovf_n;
    logic       ov_q, ov_n;
    logic       gt_q, gt_n, lt_q, lt_n, eq_q, eq_n;

    logic       accept, sgt, slt, seq;
    logic       decided, base_gt, base_lt, new_gt, new_lt;
    logic [4:0] cnt_inc;

    assign sgt     = s.a > s.b;
    assign slt     = s.a < s.b;
    assign seq     = s.a == s.b;
    assign accept  = s.in_valid && (s.start || state != IDLE);
    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            run_gt <= 1'b0;
            run_lt <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            ov_q   <= 1'b0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            state  <= state_n;
            run_gt <= run_gt_n;
            run_lt <= run_lt_n;
            cnt_q  <= cnt_n;
            ovf_q  <= ovf_n;
            ov_q   <= ov_n;
            gt_q   <= gt_n;
            lt_q   <= lt_n;
            eq_q   <= eq_n;
        end
    end

    always_comb begin
        state_n  = state;
        run_gt_n = run_gt;
        run_lt_n = run_lt;
        cnt_n    = cnt_q;
        ovf_n    = ovf_q;
        ov_n     = 1'b0;
        gt_n     = gt_q;
        lt_n     = lt_q;
        eq_n     = eq_q;
        decided  = 1'b0;
        base_gt  = run_gt;
        base_lt  = run_lt;
        new_gt   = run_gt;
        new_lt   = run_lt;

        if (accept) begin
            // A start slice restarts from "equal", even when it aborts a compare in flight.
            if (s.start) begin
                base_gt = 1'b0;
                base_lt = 1'b0;
                cnt_n   = 4'd1;
                ovf_n   = 1'b0;
            end else begin
                decided = (state == DECIDED);
                cnt_n   = cnt_inc[3:0];
            end

            new_gt = base_gt;
            new_lt = base_lt;
            if (decided) begin
                state_n = DECIDED;
            end else if (sgt) begin
                new_gt  = 1'b1;
                state_n = DECIDED;
            end else if (slt) begin
                new_lt  = 1'b1;
                state_n = DECIDED;
            end else if (seq) begin
                state_n = RUN;
            end
            run_gt_n = new_gt;
            run_lt_n = new_lt;

            if (s.last) begin
                gt_n    = new_gt;
                lt_n    = new_lt;
                eq_n    = ~new_gt & ~new_lt;
                ov_n    = 1'b1;
                state_n = IDLE;
            end else if (!s.start && cnt_inc > 5'(MAXSL)) begin
                ovf_n   = 1'b1;
                state_n = IDLE;
            end
        end
    end

    assign s.busy      = (state != IDLE);
    assign s.out_valid = ov_q;
    assign s.gt        = gt_q;
    assign s.lt        = lt_q;
    assign s.eq        = eq_q;
    assign s.cnt       = cnt_q;
    assign s.ovf       = ovf_q;
endmodule

// File: tb/tb_mag_comp_serial.sv
// Directed-vector bench for the serial magnitude comparator.
module tb_mag_comp_serial;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   p0;

    mag_comp_serial_if ifc ();

    mag_comp_serial #(.MAXSL(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ifc.out_valid === 1'b1) pulses++;

    task automatic slice(input logic st, input logic ls, input logic [1:0] av, input logic [1:0] bv);
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.start    = st;
        ifc.last     = ls;
        ifc.a        = av;
        ifc.b        = bv;
    endtask

    task automatic idle();
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.start    = 1'b0;
        ifc.last     = 1'b0;
        ifc.a        = 2'd0;
        ifc.b        = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", ifc.busy); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", ifc.out_valid); end
        checks++; if ({ifc.gt, ifc.lt, ifc.eq} !== 3'b000) begin errors++; $display("FAIL reset_gt_lt_eq got=%b want=000", {ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", ifc.cnt); end
        checks++; if (ifc.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ifc.ovf); end
        rst = 1'b0;
        idle();
    endtask

    // A=0xFF, B=0xFF in four slices
    task automatic test_equal();
        p0 = pulses;
        slice(1'b1, 1'b0, 2'd3, 2'd3);
        slice(1'b0, 1'b0, 2'd3, 2'd3);
        idle();
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL eq_mid_busy got=%b want=1", ifc.busy); end
        checks++; if (ifc.cnt !== 4'd2) begin errors++; $display("FAIL eq_mid_cnt got=%0d want=2", ifc.cnt); end
        slice(1'b0, 1'b0, 2'd3, 2'd3);
        slice(1'b0, 1'b1, 2'd3, 2'd3);
        idle();
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL eq_out_valid got=%b want=1", ifc.out_valid); end
        checks++; if ({ifc.gt, ifc.lt, ifc.eq} !== 3'b001) begin errors++; $display("FAIL eq_result got=%b want=001", {ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL eq_busy_fall got=%b want=0", ifc.busy); end
        checks++; if (ifc.cnt !== 4'd4) begin errors++; $display("FAIL eq_cnt got=%0d want=4", ifc.cnt); end
        idle();
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL eq_pulse_width got=%b want=0", ifc.out_valid); end
        checks++; if (ifc.eq !== 1'b1) begin errors++; $display("FAIL eq_hold got=%b want=1", ifc.eq); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL eq_pulse_count got=%0d want=1", pulses - p0); end
    endtask

    // A=0b1000, B=0b0111: decided on the first slice
    task automatic test_decided();
        slice(1'b1, 1'b0, 2'd2, 2'd1);
        idle();
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL dec_busy got=%b want=1", ifc.busy); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL dec_early_valid got=%b want=0", ifc.out_valid); end
        slice(1'b0, 1'b1, 2'd0, 2'd3);
        idle();
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL dec_out_valid got=%b want=1", ifc.out_valid); end
        checks++; if ({ifc.gt, ifc.lt, ifc.eq} !== 3'b100) begin errors++; $display("FAIL dec_result got=%b want=100", {ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.cnt !== 4'd2) begin errors++; $display("FAIL dec_cnt got=%0d want=2", ifc.cnt); end
    endtask

    task automatic test_single();
        slice(1'b1, 1'b1, 2'd1, 2'd2);
        idle();
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b want=1", ifc.out_valid); end
        checks++; if ({ifc.gt, ifc.lt, ifc.eq} !== 3'b010) begin errors++; $display("FAIL single_result got=%b want=010", {ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got=%0d want=1", ifc.cnt); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b want=0", ifc.busy); end
    endtask

    task automatic test_abort();
        idle();
        p0 = pulses;
        slice(1'b1, 1'b0, 2'd1, 2'd1);
        slice(1'b0, 1'b0, 2'd2, 2'd2);
        slice(1'b1, 1'b1, 2'd3, 2'd0);
        idle();
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL abort_out_valid got=%b want=1", ifc.out_valid); end
        checks++; if ({ifc.gt, ifc.lt, ifc.eq} !== 3'b100) begin errors++; $display("FAIL abort_result got=%b want=100", {ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.cnt !== 4'd1) begin errors++; $display("FAIL abort_cnt got=%0d want=1", ifc.cnt); end
        idle();
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL abort_pulse_count got=%0d want=1", pulses - p0); end
    endtask

    task automatic test_overflow();
        p0 = pulses;
        slice(1'b1, 1'b0, 2'd2, 2'd2);
        for (int i = 0; i < 7; i++) slice(1'b0, 1'b0, 2'd1, 2'd1);
        idle();
        checks++; if ({ifc.busy, ifc.ovf} !== 2'b10) begin errors++; $display("FAIL ovf_at8_busy_ovf got=%b want=10", {ifc.busy, ifc.ovf}); end
        checks++; if (ifc.cnt !== 4'd8) begin errors++; $display("FAIL ovf_at8_cnt got=%0d want=8", ifc.cnt); end
        slice(1'b0, 1'b0, 2'd1, 2'd1);
        idle();
        checks++; if (ifc.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", ifc.ovf); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL ovf_busy got=%b want=0", ifc.busy); end
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL ovf_no_pulse got=%0d want=0", pulses - p0); end
        slice(1'b0, 1'b1, 2'd3, 2'd0);
        idle();
        checks++; if ({ifc.ovf, ifc.out_valid, ifc.busy} !== 3'b100) begin errors++; $display("FAIL ovf_sticky got=%b want=100", {ifc.ovf, ifc.out_valid, ifc.busy}); end
        slice(1'b1, 1'b1, 2'd0, 2'd1);
        idle();
        checks++; if (ifc.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", ifc.ovf); end
        checks++; if ({ifc.out_valid, ifc.gt, ifc.lt, ifc.eq} !== 4'b1010) begin errors++; $display("FAIL ovf_next_result got=%b want=1010", {ifc.out_valid, ifc.gt, ifc.lt, ifc.eq}); end
    endtask

    // Eight slices with last on the eighth is the longest legal compare without overflow
    task automatic test_max_len();
        slice(1'b1, 1'b0, 2'd1, 2'd1);
        for (int i = 0; i < 6; i++) slice(1'b0, 1'b0, 2'd0, 2'd0);
        slice(1'b0, 1'b1, 2'd2, 2'd1);
        idle();
        checks++; if ({ifc.out_valid, ifc.gt, ifc.lt, ifc.eq} !== 4'b1100) begin errors++; $display("FAIL max_result got=%b want=1100", {ifc.out_valid, ifc.gt, ifc.lt, ifc.eq}); end
        checks++; if (ifc.ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got=%b want=0", ifc.ovf); end
        checks++; if (ifc.cnt !== 4'd8) begin errors++; $display("FAIL max_cnt got=%0d want=8", ifc.cnt); end
    endtask

    task automatic test_back_to_back();
        idle();
        p0 = pulses;
        slice(1'b1, 1'b1, 2'd3, 2'd3);
        @(negedge clk);
        checks++; if ({ifc.out_valid, ifc.gt, ifc.lt, ifc.eq} !== 4'b1001) begin errors++; $display("FAIL b2b_first got=%b want=1001", {ifc.out_valid, ifc.gt, ifc.lt, ifc.eq}); end
        ifc.in_valid = 1'b1; ifc.start = 1'b1; ifc.last = 1'b1; ifc.a = 2'd0; ifc.b = 2'd2;
        idle();
        checks++; if ({ifc.out_valid, ifc.gt, ifc.lt, ifc.eq} !== 4'b1010) begin errors++; $display("FAIL b2b_second got=%b want=1010", {ifc.out_valid, ifc.gt, ifc.lt, ifc.eq}); end
        idle();
        checks++; if (pulses - p0 !== 2) begin errors++; $display("FAIL b2b_pulse_count got=%0d want=2", pulses - p0); end
    endtask

    task automatic test_rst_mid();
        p0 = pulses;
        slice(1'b1, 1'b0, 2'd1, 2'd1);
        slice(1'b0, 1'b0, 2'd2, 2'd2);
        // Reset collides with a last slice that must be dropped
        slice(1'b0, 1'b1, 2'd3, 2'd0);
        rst = 1'b1;
        idle();
        checks++; if ({ifc.busy, ifc.out_valid, ifc.gt, ifc.lt, ifc.eq, ifc.ovf} !== 6'b0) begin errors++; $display("FAIL rstmid_flags got=%b want=000000", {ifc.busy, ifc.out_valid, ifc.gt, ifc.lt, ifc.eq, ifc.ovf}); end
        checks++; if (ifc.cnt !== 4'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d want=0", ifc.cnt); end
        rst = 1'b0;
        slice(1'b0, 1'b1, 2'd3, 2'd0);
        slice(1'b0, 1'b0, 2'd1, 2'd2);
        idle();
        checks++; if ({ifc.busy, ifc.gt, ifc.lt, ifc.eq, ifc.cnt} !== 8'b0) begin errors++; $display("FAIL rstmid_ignore got=%b want=00000000", {ifc.busy, ifc.gt, ifc.lt, ifc.eq, ifc.cnt}); end
        idle();
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL rstmid_no_pulse got=%0d want=0", pulses - p0); end
        slice(1'b1, 1'b1, 2'd2, 2'd2);
        idle();
        checks++; if ({ifc.out_valid, ifc.eq, ifc.cnt} !== 6'b110001) begin errors++; $display("FAIL rstmid_restart got=%b want=110001", {ifc.out_valid, ifc.eq, ifc.cnt}); end
    endtask

    initial begin
        rst          = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.start    = 1'b0;
        ifc.last     = 1'b0;
        ifc.a        = 2'd0;
        ifc.b        = 2'd0;
        test_reset();
        test_equal();
        test_decided();
        test_single();
        test_abort();
        test_overflow();
        test_max_len();
        test_back_to_back();
        test_rst_mid();
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
